// File: rtl/fp32_to_int_converter_pkg.sv
// rtl/fp32_to_int_converter_pkg.sv - FCvt stage-1 payload type, round-mode encodings, saturation constants
package fp32_to_int_converter_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [31:0] FCVT_INT_MAX  = 32'h7FFFFFFF;
  localparam logic [31:0] FCVT_INT_MIN  = 32'h80000000;
  localparam logic [31:0] FCVT_UINT_MAX = 32'hFFFFFFFF;

  typedef struct packed {
    logic        sign;
    logic [9:0]  v_expo;      // unbiased exponent, two's complement
    logic [23:0] mant;        // hidden bit included, 0 for subnormals
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        is_unsigned;
    logic [2:0]  round_mode;
  } FCvtStage1RegPath;

  // Split an FP32 word into the fields stage 2 needs
  function automatic FCvtStage1RegPath fcvt_unpack(input logic [31:0] op,
                                                   input logic        uns,
                                                   input logic [2:0]  rm);
    FCvtStage1RegPath p;
    logic [7:0]  expo;
    logic [22:0] frac;
    expo          = op[30:23];
    frac          = op[22:0];
    p.sign        = op[31];
    p.v_expo      = {2'b00, expo} - 10'd127;
    p.mant        = {(expo != 8'd0), frac};
    p.is_nan      = (expo == 8'hFF) && (frac != 23'd0);
    p.is_inf      = (expo == 8'hFF) && (frac == 23'd0);
    p.is_zero     = (expo == 8'd0) && (frac == 23'd0);
    p.is_unsigned = uns;
    p.round_mode  = rm;
    return p;
  endfunction

endpackage

// File: rtl/fcvt_round_saturate.sv
// rtl/fcvt_round_saturate.sv - stage-2 shift/round/range-check/saturate; fflags port only with FP_CVT_FFLAGS_EN
module fcvt_round_saturate
  import fp32_to_int_converter_pkg::*;
(
  input  FCvtStage1RegPath s1,
  output logic [31:0]      result
`ifdef FP_CVT_FFLAGS_EN
  ,
  output logic [4:0]       fflags
`endif
);

  logic signed [9:0] e;
  logic signed [9:0] sh_full;
  logic              big;
  logic              tiny;
  logic [5:0]        sh;
  logic [63:0]       wide;
  logic [31:0]       int_part;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [32:0]       mag;
  logic              in_range;
  logic              invalid;

  // Align mantissa into a 32.32 fixed-point word; exponents past 31 clamp the shift
  always_comb begin
    e       = signed'(s1.v_expo);
    sh_full = e + 10'sd9;
    big     = (e > 10'sd31);
    tiny    = (e < -10'sd9);
    sh      = big ? 6'd40 : (tiny ? 6'd0 : sh_full[5:0]);
    wide    = {40'd0, s1.mant} << sh;
    if (tiny) begin
      int_part = 32'd0;
      guard    = 1'b0;
      sticky   = |s1.mant;
    end else begin
      int_part = wide[63:32];
      guard    = wide[31];
      sticky   = |wide[30:0];
    end
  end

  // Rounding increment; encodings 5-7 fall through to round-to-nearest-even
  always_comb begin
    case (s1.round_mode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1.sign & (guard | sticky);
      RM_RUP:  inc = ~s1.sign & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | int_part[0]);
    endcase
    mag = {1'b0, int_part} + {32'd0, inc};
  end

  // Range check on the rounded value, then saturate or sign-apply
  always_comb begin
    if (big) begin
      in_range = 1'b0;
    end else if (s1.is_unsigned) begin
      in_range = s1.sign ? (mag == 33'd0) : ~mag[32];
    end else begin
      in_range = s1.sign ? (mag <= 33'h080000000) : (mag <= 33'h07FFFFFFF);
    end
    invalid = s1.is_nan | s1.is_inf | ~in_range;

    if (s1.is_zero) begin
      result = 32'd0;
    end else if (s1.is_nan) begin
      result = s1.is_unsigned ? FCVT_UINT_MAX : FCVT_INT_MAX;
    end else if (invalid) begin
      if (s1.sign) result = s1.is_unsigned ? 32'd0 : FCVT_INT_MIN;
      else         result = s1.is_unsigned ? FCVT_UINT_MAX : FCVT_INT_MAX;
    end else begin
      result = s1.sign ? (~mag[31:0] + 32'd1) : mag[31:0];
    end
  end

`ifdef FP_CVT_FFLAGS_EN
  // NV on invalid/saturation, otherwise NX from discarded bits; zeros have no discarded bits
  always_comb begin
    fflags = {invalid, 3'b000, ~invalid & (guard | sticky)};
  end
`endif

endmodule

// File: rtl/fp32_to_int_converter.sv
// rtl/fp32_to_int_converter.sv - two-stage FP32->int32/uint32 converter; FP_CVT_FFLAGS_EN enables fflags
module fp32_to_int_converter
  import fp32_to_int_converter_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] lhs,
  input  logic        is_unsigned,
  input  logic [2:0]  round_mode,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  if (LATENCY != 2) begin : g_bad_latency
    $error("fp32_to_int_converter: LATENCY must be 2");
  end

  FCvtStage1RegPath s1;
  logic             s1_valid;
  logic [31:0]      s2_result;

  // Stage 1: unpack and classify; flush beats stall, stall beats capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1       <= fcvt_unpack(lhs, is_unsigned, round_mode);
    end
  end

`ifdef FP_CVT_FFLAGS_EN
  logic [4:0] s2_fflags;

  fcvt_round_saturate u_round_saturate (
    .s1     (s1),
    .result (s2_result),
    .fflags (s2_fflags)
  );

  // Output flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         fflags <= 5'd0;
    else if (!flush && !stall) fflags <= s2_fflags;
  end
`else
  fcvt_round_saturate u_round_saturate (
    .s1     (s1),
    .result (s2_result)
  );

  assign fflags = 5'd0;
`endif

  // Output stage: result register and its valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      result    <= s2_result;
    end
  end

endmodule
